// File: rtl/car_sensor_conditioner.sv
// Conditions the side-road loop sensor into a queued-car count and the car_req input of traffic_light.
// Optional arrival statistic on total_cars is enabled by defining CAR_SENSOR_STATS_EN.
module car_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int SERVICE_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  input  logic [2:0]       light_state,
  output logic             car_req,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow,
  output logic [15:0]      total_cars
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SVC_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SVC_W-1:0] SVC_LAST = SVC_W'(SERVICE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SERVE} state_t;

  logic             sync1, sync2;
  logic             debounced, debounced_q;
  logic [DEB_W-1:0] deb_cnt;
  logic [SVC_W-1:0] svc_cnt;
  logic             green, arrival, depart, svc_last;
  logic [CNT_W-1:0] count_next;
  logic             ovf_set;
  state_t           state, state_next;
  logic             fsm_idle;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      debounced   <= 1'b0;
      debounced_q <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      sync1       <= sensor_raw;
      sync2       <= sync1;
      debounced_q <= debounced;
      if (sync2 == debounced) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        debounced <= ~debounced;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Only an exact green code services the queue; illegal codes behave as red.
  assign green    = (light_state == 3'b001);
  assign arrival  = debounced & ~debounced_q;
  assign svc_last = (svc_cnt == SVC_LAST);
  assign depart   = green & svc_last & (car_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      svc_cnt <= '0;
    end else if (!green || svc_last) begin
      svc_cnt <= '0;
    end else begin
      svc_cnt <= svc_cnt + SVC_W'(1);
    end
  end

  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = car_count;
    ovf_set    = 1'b0;
    case ({arrival, depart})
      2'b10: begin
        if (car_count == CNT_MAX) ovf_set = 1'b1;
        else                      count_next = car_count + CNT_W'(1);
      end
      2'b01:   count_next = car_count - CNT_W'(1);
      default: count_next = car_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_count <= '0;
      car_req   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      car_count <= count_next;
      car_req   <= (count_next != '0);
      if (ovf_set) overflow <= 1'b1;
    end
  end

`ifdef CAR_SENSOR_STATS_EN
  logic [15:0] total_q;

  // Lost arrivals at saturation still count as vehicles seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       total_q <= '0;
    else if (arrival) total_q <= total_q + 16'd1;
  end

  assign total_cars = total_q;
`else
  assign total_cars = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Transitions follow count_next so the state lines up with the registered car_req.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (count_next != '0) state_next = S_WAIT;
      S_WAIT: begin
        if (count_next == '0) state_next = S_IDLE;
        else if (green)       state_next = S_SERVE;
      end
      S_SERVE: begin
        if (count_next == '0) state_next = S_IDLE;
        else if (!green)      state_next = S_WAIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fsm_idle = (state == S_IDLE);
  end

  a_req_idle: assert property (@(posedge clk) disable iff (!rst_n) car_req == !fsm_idle);

endmodule
